// File: rtl/cache_fill_wb_ctl_if.sv
// cache_fill_wb_ctl_if: miss request, PSRAM burst, data/tag RAM and status signals of the line fill controller
interface cache_fill_wb_ctl_if;
  logic        miss_req;
  logic [22:0] miss_addr;
  logic [1:0]  victim_way;
  logic        victim_dirty;
  logic [12:0] victim_tag;
  logic        busy;
  logic        WB_RUN;
  logic        WB_RUN_CLR;
  logic        RFILL_RUN;
  logic        RFILL_RUN_CLR;
  logic [31:0] get_psram_rdata;
  logic        ps_cmd_valid;
  logic        ps_cmd_ready;
  logic        ps_cmd_we;
  logic [22:0] ps_cmd_addr;
  logic [31:0] ps_wdata;
  logic        ps_wdata_valid;
  logic        ps_wdata_ready;
  logic [31:0] ps_rdata;
  logic        ps_rdata_valid;
  logic        dram_ren;
  logic [9:0]  dram_raddr;
  logic [31:0] dram_rdata;
  logic        dram_we;
  logic [9:0]  dram_waddr;
  logic [31:0] dram_wdata;
  logic        tag_we;
  logic [1:0]  tag_way;
  logic [3:0]  tag_line;
  logic [14:0] tag_wdata;
  logic [15:0] stat_fill_cnt;
  logic [15:0] stat_wb_cnt;
  modport master (
    input  miss_req, miss_addr, victim_way, victim_dirty, victim_tag,
           ps_cmd_ready, ps_wdata_ready, ps_rdata, ps_rdata_valid, dram_rdata,
    output busy, WB_RUN, WB_RUN_CLR, RFILL_RUN, RFILL_RUN_CLR, get_psram_rdata,
           ps_cmd_valid, ps_cmd_we, ps_cmd_addr, ps_wdata, ps_wdata_valid,
           dram_ren, dram_raddr, dram_we, dram_waddr, dram_wdata,
           tag_we, tag_way, tag_line, tag_wdata, stat_fill_cnt, stat_wb_cnt
  );
  modport slave (
    output miss_req, miss_addr, victim_way, victim_dirty, victim_tag,
           ps_cmd_ready, ps_wdata_ready, ps_rdata, ps_rdata_valid, dram_rdata,
    input  busy, WB_RUN, WB_RUN_CLR, RFILL_RUN, RFILL_RUN_CLR, get_psram_rdata,
           ps_cmd_valid, ps_cmd_we, ps_cmd_addr, ps_wdata, ps_wdata_valid,
           dram_ren, dram_raddr, dram_we, dram_waddr, dram_wdata,
           tag_we, tag_way, tag_line, tag_wdata, stat_fill_cnt, stat_wb_cnt
  );
endinterface

// File: rtl/cache_fill_wb_ctl.sv
// cache_fill_wb_ctl: dirty-victim write-back then line read-fill into cache RAMs; CACHE_FILL_STATS_EN adds fill/write-back counters
module cache_fill_wb_ctl #(
  parameter int LINE_WORDS = 16
) (
  input logic cpuclk,
  input logic WSHRST_n,
  cache_fill_wb_ctl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, RF_CMD, RF_DATA, TAG_UPD} state_t;
  localparam logic [3:0] LAST = 4'(LINE_WORDS - 1);
  state_t      r_st;
  logic [22:2] r_addr;
  logic [1:0]  r_way;
  logic [12:0] r_tag;
  logic [4:0]  r_rd_cnt;
  logic [3:0]  r_ac_cnt;
  logic        r_ov, r_sv, r_rp;
  logic [31:0] r_od, r_sd, r_crit;
  logic        w_acc, w_take, w_issue, w_last_wb, w_beat, w_tag;
  logic [1:0]  w_occ;
  // write-back pipeline control: a RAM read is issued only if output + skid can absorb it even under stall
  always_comb begin
    w_acc     = r_st == WB_DATA && r_ov && bus.ps_wdata_ready;
    w_take    = !r_ov || w_acc;
    w_occ     = 2'(r_ov) + 2'(r_sv) + 2'(r_rp);
    w_issue   = r_st == WB_DATA && !r_rd_cnt[4] && (w_occ - 2'(w_acc)) <= 2'd1;
    w_last_wb = w_acc && r_ac_cnt == LAST;
    w_beat    = r_st == RF_DATA && bus.ps_rdata_valid;
    w_tag     = r_st == TAG_UPD;
  end
  assign bus.busy            = r_st != IDLE;
  assign bus.WB_RUN          = r_st inside {WB_CMD, WB_DATA};
  assign bus.WB_RUN_CLR      = w_last_wb;
  assign bus.RFILL_RUN       = r_st inside {RF_CMD, RF_DATA, TAG_UPD};
  assign bus.RFILL_RUN_CLR   = w_tag;
  assign bus.get_psram_rdata = r_crit;
  assign bus.ps_cmd_valid    = r_st inside {WB_CMD, RF_CMD};
  assign bus.ps_cmd_we       = r_st == WB_CMD;
  assign bus.ps_cmd_addr     = r_st == WB_CMD ? {r_tag, r_addr[9:6], 6'b0} :
                               r_st == RF_CMD ? {r_addr[22:6], 6'b0} : 23'b0;
  assign bus.ps_wdata        = r_od;
  assign bus.ps_wdata_valid  = r_ov;
  assign bus.dram_ren        = w_issue;
  assign bus.dram_raddr      = {r_way, r_addr[9:6], r_rd_cnt[3:0]};
  assign bus.dram_we         = w_beat;
  assign bus.dram_waddr      = {r_way, r_addr[9:6], r_ac_cnt};
  assign bus.dram_wdata      = w_beat ? bus.ps_rdata : 32'b0;
  assign bus.tag_we          = w_tag;
  assign bus.tag_way         = w_tag ? r_way : 2'b0;
  assign bus.tag_line        = w_tag ? r_addr[9:6] : 4'b0;
  assign bus.tag_wdata       = w_tag ? {2'b10, r_addr[22:10]} : 15'b0;
  // controller FSM with write-back skid buffer, fill beat counter and critical-word capture
  always_ff @(posedge cpuclk) begin
    if (!WSHRST_n) begin
      r_st     <= IDLE;
      r_addr   <= '0;
      r_way    <= '0;
      r_tag    <= '0;
      r_rd_cnt <= '0;
      r_ac_cnt <= '0;
      r_ov     <= 1'b0;
      r_sv     <= 1'b0;
      r_rp     <= 1'b0;
      r_od     <= '0;
      r_sd     <= '0;
      r_crit   <= '0;
    end else begin
      unique case (r_st)
        IDLE: if (bus.miss_req) begin
          r_addr <= bus.miss_addr[22:2];
          r_way  <= bus.victim_way;
          r_tag  <= bus.victim_tag;
          r_st   <= bus.victim_dirty ? WB_CMD : RF_CMD;
        end
        WB_CMD: if (bus.ps_cmd_ready) r_st <= WB_DATA;
        WB_DATA: begin
          if (w_issue) r_rd_cnt <= r_rd_cnt + 5'd1;
          if (w_acc) r_ac_cnt <= r_ac_cnt + 4'd1;
          if (w_take) begin
            r_ov <= r_sv || r_rp;
            r_od <= r_sv ? r_sd : bus.dram_rdata;
            r_sv <= r_sv && r_rp;
            r_sd <= bus.dram_rdata;
          end else if (r_rp) begin
            r_sv <= 1'b1;
            r_sd <= bus.dram_rdata;
          end
          r_rp <= w_issue;
          if (w_last_wb) begin
            r_st     <= RF_CMD;
            r_rd_cnt <= '0;
            r_ac_cnt <= '0;
          end
        end
        RF_CMD: if (bus.ps_cmd_ready) r_st <= RF_DATA;
        RF_DATA: if (bus.ps_rdata_valid) begin
          r_ac_cnt <= r_ac_cnt + 4'd1;
          if (r_ac_cnt == r_addr[5:2]) r_crit <= bus.ps_rdata;
          if (r_ac_cnt == LAST) r_st <= TAG_UPD;
        end
        TAG_UPD: r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
    end
  end
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] r_fill_cnt, r_wb_cnt;
  // wrapping fill and write-back event counters
  always_ff @(posedge cpuclk) begin
    if (!WSHRST_n) begin
      r_fill_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_tag) r_fill_cnt <= r_fill_cnt + 16'd1;
      if (w_last_wb) r_wb_cnt <= r_wb_cnt + 16'd1;
    end
  end
  assign bus.stat_fill_cnt = r_fill_cnt;
  assign bus.stat_wb_cnt   = r_wb_cnt;
`else
  assign bus.stat_fill_cnt = 16'b0;
  assign bus.stat_wb_cnt   = 16'b0;
`endif
endmodule

// File: tb/tb_cache_fill_wb_ctl.sv
// tb_cache_fill_wb_ctl: directed scenarios for the line fill / write-back controller
module tb_cache_fill_wb_ctl;
  logic cpuclk = 1'b0;
  logic WSHRST_n;
  always #5 cpuclk = ~cpuclk;
  cache_fill_wb_ctl_if bus();
  cache_fill_wb_ctl #(.LINE_WORDS(16)) dut (.cpuclk(cpuclk), .WSHRST_n(WSHRST_n), .bus(bus));
  logic [31:0] mem [1024];
  int total, bad, cyc, tot_sent, rd_cmd_cnt, stall_n;
  bit rmode, gap;
  logic [31:0] wb_q[$], wd_q[$];
  logic [9:0]  wa_q[$];
  logic [22:0] cmd_addr_q[$];
  bit          cmd_we_q[$];
  int wb_clr_cnt, rf_clr_cnt, tag_cnt, overlap_bad, clr_bad, stall_seen, stall_bad;
  logic [14:0] tag_wd;
  logic [1:0]  tag_wy;
  logic [3:0]  tag_ln;
  bit pv, pr;
  logic [31:0] pd;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rdat(input int n, input int k);
    return 32'hD000_0000 | 32'(n << 8) | 32'(k);
  endfunction
  // data RAM model with one-cycle read latency
  always @(posedge cpuclk) if (bus.dram_ren) bus.dram_rdata <= mem[bus.dram_raddr];
  // event logger sampled on the falling edge
  always @(negedge cpuclk) begin
    if (bus.WB_RUN && bus.RFILL_RUN) overlap_bad++;
    if (bus.WB_RUN_CLR) begin
      wb_clr_cnt++;
      if (!bus.WB_RUN || !(bus.ps_wdata_valid && bus.ps_wdata_ready) || wb_q.size() != 15) clr_bad++;
    end
    if (pv && !pr) begin
      stall_seen++;
      if (!bus.ps_wdata_valid || bus.ps_wdata !== pd) stall_bad++;
    end
    pv = bus.ps_wdata_valid;
    pr = bus.ps_wdata_ready;
    pd = bus.ps_wdata;
    if (bus.ps_wdata_valid && bus.ps_wdata_ready) wb_q.push_back(bus.ps_wdata);
    if (bus.ps_cmd_valid && bus.ps_cmd_ready) begin
      cmd_we_q.push_back(bus.ps_cmd_we);
      cmd_addr_q.push_back(bus.ps_cmd_addr);
      if (!bus.ps_cmd_we) rd_cmd_cnt++;
    end
    if (bus.dram_we) begin
      wa_q.push_back(bus.dram_waddr);
      wd_q.push_back(bus.dram_wdata);
    end
    if (bus.tag_we) begin
      tag_cnt++;
      tag_wd = bus.tag_wdata;
      tag_wy = bus.tag_way;
      tag_ln = bus.tag_line;
    end
    if (bus.RFILL_RUN_CLR) rf_clr_cnt++;
  end
  task automatic tick();
    @(posedge cpuclk);
    #1;
    cyc++;
    bus.ps_cmd_ready = rmode ? !cyc[0] : 1'b1;
    if (rmode && wb_q.size() == 7 && stall_n < 5) begin
      bus.ps_wdata_ready = 1'b0;
      stall_n++;
    end else bus.ps_wdata_ready = rmode ? cyc[0] : 1'b1;
    if (tot_sent < rd_cmd_cnt * 16 && (!gap || cyc[0])) begin
      bus.ps_rdata_valid = 1'b1;
      bus.ps_rdata = rdat(rd_cmd_cnt, tot_sent % 16);
      tot_sent++;
    end else begin
      bus.ps_rdata_valid = 1'b0;
      bus.ps_rdata = '0;
    end
  endtask
  task automatic clr_logs();
    wb_q.delete(); wd_q.delete(); wa_q.delete(); cmd_addr_q.delete(); cmd_we_q.delete();
    wb_clr_cnt = 0; rf_clr_cnt = 0; tag_cnt = 0; overlap_bad = 0; clr_bad = 0;
    stall_seen = 0; stall_bad = 0; stall_n = 0;
  endtask
  task automatic miss(input logic [22:0] a, input logic [1:0] w, input bit d, input logic [12:0] t);
    bus.miss_addr = a; bus.victim_way = w; bus.victim_dirty = d; bus.victim_tag = t;
    bus.miss_req = 1'b1;
    tick();
    bus.miss_req = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (rf_clr_cnt == 0 && n < 500) begin
      tick();
      n++;
    end
    chk("done_in_time", 32'(rf_clr_cnt != 0), 1);
  endtask
  task automatic chk_cmd(input int i, input bit we, input logic [22:0] a);
    chk("cmd_we", 32'(cmd_we_q[i]), 32'(we));
    chk("cmd_addr", 32'(cmd_addr_q[i]), 32'(a));
  endtask
  task automatic check_wb(input logic [1:0] way, input logic [3:0] line);
    chk("wb_beats", wb_q.size(), 16);
    for (int k = 0; k < 16 && k < wb_q.size(); k++) chk("wb_data", wb_q[k], mem[{way, line, 4'(k)}]);
    chk("wb_clr_pulse", wb_clr_cnt, 1);
    chk("wb_clr_timing", clr_bad, 0);
    chk("run_overlap", overlap_bad, 0);
  endtask
  task automatic check_fill(input logic [1:0] way, input logic [3:0] line, input logic [3:0] ck, input logic [12:0] tag);
    int n = rd_cmd_cnt;
    chk("fill_beats", wa_q.size(), 16);
    for (int k = 0; k < 16 && k < wa_q.size(); k++) begin
      chk("fill_waddr", 32'(wa_q[k]), 32'({way, line, 4'(k)}));
      chk("fill_wdata", wd_q[k], rdat(n, k));
    end
    chk("crit_word", bus.get_psram_rdata, rdat(n, ck));
    chk("tag_we_cnt", tag_cnt, 1);
    chk("tag_wdata", 32'(tag_wd), 32'({2'b10, tag}));
    chk("tag_way", 32'(tag_wy), 32'(way));
    chk("tag_line", 32'(tag_ln), 32'(line));
    chk("rfill_clr_pulse", rf_clr_cnt, 1);
    chk("busy_after", 32'(bus.busy), 0);
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_wbrun"}, 32'(bus.WB_RUN), 0);
    chk({tag, "_rfrun"}, 32'(bus.RFILL_RUN), 0);
    chk({tag, "_cmdv"}, 32'(bus.ps_cmd_valid), 0);
    chk({tag, "_wdv"}, 32'(bus.ps_wdata_valid), 0);
    chk({tag, "_ren"}, 32'(bus.dram_ren), 0);
    chk({tag, "_dwe"}, 32'(bus.dram_we), 0);
    chk({tag, "_twe"}, 32'(bus.tag_we), 0);
    chk({tag, "_crit"}, bus.get_psram_rdata, 0);
    chk({tag, "_fills"}, 32'(bus.stat_fill_cnt), 0);
    chk({tag, "_wbs"}, 32'(bus.stat_wb_cnt), 0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE ^ 16'(i * 37), 16'(i)};
    WSHRST_n = 1'b0;
    bus.miss_req = 0; bus.miss_addr = 0; bus.victim_way = 0; bus.victim_dirty = 0; bus.victim_tag = 0;
    bus.ps_cmd_ready = 1; bus.ps_wdata_ready = 1; bus.ps_rdata = 0; bus.ps_rdata_valid = 0;
    rmode = 0; gap = 0;
    clr_logs();
    repeat (3) tick();
    check_quiet("reset");
    WSHRST_n = 1'b1;
    tick();
    // read data outside a fill must not reach the data RAM
    clr_logs();
    bus.ps_rdata_valid = 1'b1;
    bus.ps_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("idle_rvalid_ignored", wa_q.size(), 0);
    // clean miss
    clr_logs();
    miss(23'h012344, 2'd2, 1'b0, 13'h0);
    wait_done();
    chk("clean_cmds", cmd_addr_q.size(), 1);
    chk_cmd(0, 1'b0, 23'h012340);
    chk("clean_no_wb", wb_q.size(), 0);
    check_fill(2'd2, 4'hD, 4'd1, 13'h048);
    // dirty miss, full throughput
    clr_logs();
    miss(23'h0000C8, 2'd1, 1'b1, 13'h1FFF);
    wait_done();
    chk("dirty_cmds", cmd_addr_q.size(), 2);
    chk_cmd(0, 1'b1, 23'h7FFCC0);
    chk_cmd(1, 1'b0, 23'h0000C0);
    check_wb(2'd1, 4'd3);
    check_fill(2'd1, 4'd3, 4'd2, 13'h0);
    // dirty miss with toggling/stalled ready and gapped read data
    clr_logs();
    rmode = 1; gap = 1;
    miss(23'h05567C, 2'd3, 1'b1, 13'h0AA);
    wait_done();
    rmode = 0; gap = 0;
    chk_cmd(0, 1'b1, 23'h02AA40);
    check_wb(2'd3, 4'd9);
    chk("stall_stable", stall_bad, 0);
    chk("stalls_seen", 32'(stall_seen >= 5), 1);
    check_fill(2'd3, 4'd9, 4'd15, 13'h155);
    // miss during fill ignored, miss on first idle cycle accepted
    clr_logs();
    miss(23'h1ABCD4, 2'd0, 1'b0, 13'h0);
    n = 0;
    while (wa_q.size() < 5 && n < 200) begin tick(); n++; end
    chk("rf_mid_reached", 32'(wa_q.size() >= 5), 1);
    miss(23'h000000, 2'd1, 1'b1, 13'h123);
    wait_done();
    chk("busy_miss_ignored", cmd_addr_q.size(), 1);
    chk_cmd(0, 1'b0, 23'h1ABCC0);
    check_fill(2'd0, 4'd3, 4'd5, 13'h6AF);
    clr_logs();
    miss(23'h7FFFFC, 2'd3, 1'b0, 13'h0);
    chk("b2b_cmd_valid", 32'(bus.ps_cmd_valid), 1);
    chk("b2b_cmd_addr", 32'(bus.ps_cmd_addr), 32'h7FFFC0);
    wait_done();
    check_fill(2'd3, 4'hF, 4'hF, 13'h1FFF);
    // reset in the middle of a write-back
    clr_logs();
    miss(23'h000100, 2'd0, 1'b1, 13'h0F0);
    n = 0;
    while (wb_q.size() < 9 && n < 200) begin tick(); n++; end
    chk("wb_mid_reached", wb_q.size(), 9);
    WSHRST_n = 1'b0;
    tick();
    check_quiet("midrst");
    WSHRST_n = 1'b1;
    tick();
    clr_logs();
    miss(23'h000100, 2'd0, 1'b1, 13'h0F0);
    wait_done();
    chk_cmd(0, 1'b1, 23'h03C100);
    check_wb(2'd0, 4'd4);
    check_fill(2'd0, 4'd4, 4'd0, 13'h0);
`ifdef CACHE_FILL_STATS_EN
    chk("stat_fills", 32'(bus.stat_fill_cnt), 1);
    chk("stat_wbs", 32'(bus.stat_wb_cnt), 1);
`else
    chk("stat_fills", 32'(bus.stat_fill_cnt), 0);
    chk("stat_wbs", 32'(bus.stat_wb_cnt), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_fill_wb_ctl.md
CACHE_FILL_WB_CTL -- requirements
Module: cache_fill_wb_ctl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, words per 64-byte line; only 16 is supported.
REQ-002 SHALL have ports:
- cpuclk  in  1  sole clock.
- WSHRST_n  in  1  reset, synchronous, active-low.
- miss_req  in  1  one-cycle miss request.
- miss_addr  in  23  miss byte address.
- victim_way  in  2  way to replace.
- victim_dirty  in  1  victim needs write-back.
- victim_tag  in  13  victim tag [22:10].
- busy  out  1  controller not idle.
- WB_RUN  out  1  write-back in progress.
- WB_RUN_CLR  out  1  write-back done pulse.
- RFILL_RUN  out  1  read-fill in progress.
- RFILL_RUN_CLR  out  1  read-fill done pulse.
- get_psram_rdata  out  32  critical word of the fill.
- ps_cmd_valid  out  1  PSRAM command valid.
- ps_cmd_ready  in  1  PSRAM command accepted.
- ps_cmd_we  out  1  1 = write burst, 0 = read burst.
- ps_cmd_addr  out  23  line-aligned burst address.
- ps_wdata  out  32  write-burst data.
- ps_wdata_valid  out  1  write-burst data valid.
- ps_wdata_ready  in  1  write-burst data accepted.
- ps_rdata  in  32  read-burst data.
- ps_rdata_valid  in  1  read-burst data valid (no backpressure).
- dram_ren  out  1  cache data RAM read enable.
- dram_raddr  out  10  data RAM read address {way, line, word}.
- dram_rdata  in  32  data RAM read data, 1-cycle latency.
- dram_we  out  1  data RAM write enable.
- dram_waddr  out  10  data RAM write address.
- dram_wdata  out  32  data RAM write data.
- tag_we  out  1  tag RAM write enable.
- tag_way  out  2  tag RAM way.
- tag_line  out  4  tag RAM line.
- tag_wdata  out  15  tag RAM write data {valid, dirty, tag[22:10]}.
- stat_fill_cnt  out  16  fill count.
- stat_wb_cnt  out  16  write-back count.

Function
REQ-003 SHALL implement the states IDLE, WB_CMD, WB_DATA, RF_CMD, RF_DATA, TAG_UPD.
REQ-004 In IDLE, miss_req=1 SHALL latch miss_addr, victim_way, victim_dirty and victim_tag, and SHALL go to WB_CMD if victim_dirty=1, else to RF_CMD; miss_req SHALL be ignored outside IDLE.
REQ-005 busy SHALL be 1 in every state except IDLE; WB_RUN SHALL be 1 in WB_CMD and WB_DATA; RFILL_RUN SHALL be 1 in RF_CMD, RF_DATA and TAG_UPD.
REQ-006 In WB_CMD, the block SHALL drive ps_cmd_valid=1, ps_cmd_we=1 and ps_cmd_addr={victim_tag, miss_addr[9:6], 6'b0}, holding all three stable until ps_cmd_ready; it SHALL then go to WB_DATA.
REQ-007 In WB_DATA, the block SHALL read data RAM words 0..15 of {victim_way, miss_addr[9:6]} in order and present them on ps_wdata in order.
- ps_wdata SHALL hold stable while ps_wdata_valid=1 and ps_wdata_ready=0, using a skid entry.
- No word SHALL be lost or duplicated.
- At full throughput, one beat SHALL be accepted per cycle after a 1-cycle RAM latency.
REQ-008 In the cycle the 16th write beat is accepted, WB_RUN_CLR SHALL be 1 for one cycle while WB_RUN is still 1, and the next state SHALL be RF_CMD.
REQ-009 In RF_CMD, the block SHALL drive ps_cmd_valid=1, ps_cmd_we=0 and ps_cmd_addr={miss_addr[22:6], 6'b0} until ps_cmd_ready, then go to RF_DATA.
REQ-010 In RF_DATA, each ps_rdata_valid beat k (k=0..15) SHALL produce, in the same cycle, dram_we=1, dram_waddr={way, line, k} and dram_wdata=ps_rdata.
REQ-011 When k equals miss_addr[5:2], get_psram_rdata SHALL register ps_rdata; it SHALL hold that value until the next fill captures a new one.
REQ-012 After beat 15, the block SHALL enter TAG_UPD for exactly one cycle, driving tag_we=1, tag_way=way, tag_line=miss_addr[9:6], tag_wdata={1, 0, miss_addr[22:10]} and RFILL_RUN_CLR=1; it SHALL then return to IDLE.
REQ-013 ps_rdata_valid outside RF_DATA SHALL be ignored.
REQ-014 A miss_req in the first IDLE cycle after TAG_UPD SHALL be accepted.

Reset
REQ-015 While WSHRST_n=0 at a cpuclk edge, including mid-burst, the block SHALL enter IDLE, clear the word counter and skid entry, and drive every output except get_psram_rdata to 0; get_psram_rdata SHALL reset to 0.

Configuration
REQ-016 With CACHE_FILL_STATS_EN defined, the counters SHALL behave as follows; both SHALL wrap at 16 bits and clear on reset.
- stat_fill_cnt SHALL increment on each TAG_UPD.
- stat_wb_cnt SHALL increment on each WB_RUN_CLR.
REQ-017 With CACHE_FILL_STATS_EN undefined, both counters SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-018 Clean miss, miss_addr=0x012344, ready always 1 -> read cmd at 0x012340; 16 dram_we at {way, 4'hD, 0..15}; get_psram_rdata=beat 1; tag_wdata={1, 0, 0x048}; RFILL_RUN_CLR 1 cycle.
REQ-019 Dirty miss with victim_tag=0x1FFF, line 3 -> write cmd at 0x7FFCC0 with 16 beats equal to RAM words 0..15, WB_RUN_CLR pulse, then read fill; WB_RUN and RFILL_RUN never both 1.
REQ-020 ps_wdata_ready toggling 1010... and held 0 for 5 cycles at beat 7 -> beat order 0..15 intact and ps_wdata stable while stalled.
REQ-021 miss_req pulsed during RF_DATA -> ignored; second miss_req in the first IDLE cycle -> new cmd issued.
REQ-022 WSHRST_n=0 at write beat 9 -> next cycle IDLE, all outputs 0; a subsequent miss completes normally, and with CACHE_FILL_STATS_EN defined, stat counts are 1 fill and 1 write-back after one dirty miss.
